// File: rtl/cic_decimator.sv
// Purpose: N-stage, CH-channel CIC decimator (integrate at input rate, comb at rate/R).
// Latency: R-th sample of a block sampled at edge c -> o_valid strobes in cycle c+N+1.
// Backpressure: none; i_valid may be high every cycle, gaps stall only the integrators.
module cic_decimator #(
    parameter int IW = 19,
    parameter int N  = 3,
    parameter int R  = 16,
    parameter int M  = 1,
    parameter int CH = 2,
    parameter int GW = IW + N * $clog2(R * M),
    parameter int OW = GW
) (
    input  logic               lr_clock,
    input  logic               i_reset_n,
    input  logic               i_valid,
    input  logic [CH*IW-1:0]   i_data,
    output logic               o_valid,
    output logic [CH*OW-1:0]   o_data
);

    localparam int PW = $clog2(R);
    localparam logic [PW-1:0] LAST = PW'(R - 1);

    typedef logic [GW-1:0] acc_t;

    // Integrator registers, decimation register, comb results and comb delay lines.
    acc_t integ     [CH][N];
    acc_t integ_nxt [CH][N];
    acc_t x_ext     [CH];
    acc_t dec_r     [CH];
    acc_t comb_r    [CH][N];
    acc_t comb_in   [CH][N];
    acc_t dly       [CH][N][M];

    // tok[0]: decimation register holds a fresh value; tok[k]: comb stage k output is fresh.
    logic [N:0]    tok;
    logic [PW-1:0] phase;
    logic          accept_last;

    assign accept_last = i_valid && (phase == LAST);

    // Sign extension, next integrator values (register form) and comb stage inputs.
    always_comb begin
        for (int c = 0; c < CH; c++) begin
            x_ext[c] = {{(GW-IW){i_data[c*IW+IW-1]}}, i_data[c*IW +: IW]};
            integ_nxt[c][0] = integ[c][0] + x_ext[c];
            comb_in[c][0]   = dec_r[c];
            for (int k = 1; k < N; k++) begin
                integ_nxt[c][k] = integ[c][k] + integ[c][k-1];
                comb_in[c][k]   = comb_r[c][k-1];
            end
        end
    end

    // Integrators advance only on accepted samples; wrap-around is intentional.
    always_ff @(posedge lr_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            for (int c = 0; c < CH; c++)
                for (int k = 0; k < N; k++)
                    integ[c][k] <= '0;
        end else if (i_valid) begin
            for (int c = 0; c < CH; c++)
                for (int k = 0; k < N; k++)
                    integ[c][k] <= integ_nxt[c][k];
        end
    end

    // Phase counter; on the last sample of a block capture the new last-integrator value.
    always_ff @(posedge lr_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            phase  <= '0;
            tok[0] <= 1'b0;
            for (int c = 0; c < CH; c++)
                dec_r[c] <= '0;
        end else begin
            tok[0] <= accept_last;
            if (i_valid)
                phase <= (phase == LAST) ? '0 : phase + 1'b1;
            if (accept_last)
                for (int c = 0; c < CH; c++)
                    dec_r[c] <= integ_nxt[c][N-1];
        end
    end

    // Comb pipeline: each stage fires only when the token passes it, then shifts its delay line.
    always_ff @(posedge lr_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            tok[N:1] <= '0;
            for (int c = 0; c < CH; c++)
                for (int k = 0; k < N; k++) begin
                    comb_r[c][k] <= '0;
                    for (int j = 0; j < M; j++)
                        dly[c][k][j] <= '0;
                end
        end else begin
            tok[N:1] <= tok[N-1:0];
            for (int c = 0; c < CH; c++)
                for (int k = 0; k < N; k++)
                    if (tok[k]) begin
                        comb_r[c][k] <= comb_in[c][k] - dly[c][k][M-1];
                        dly[c][k][0] <= comb_in[c][k];
                        for (int j = 1; j < M; j++)
                            dly[c][k][j] <= dly[c][k][j-1];
                    end
        end
    end

    assign o_valid = tok[N];

    // Output keeps the top OW bits of the last comb stage (truncation toward -inf).
    for (genvar c = 0; c < CH; c++) begin : g_out
        assign o_data[c*OW +: OW] = comb_r[c][N-1][GW-1 -: OW];
    end

endmodule

// File: tb/tb_cic_decimator.sv
`timescale 1ns/1ps
module tb_cic_decimator;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n = 1'b0;
    int   cyc   = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp  = 0;
    int n_fail = 0;

    // Default configuration: IW=19 N=3 R=16 M=1 CH=2 -> GW=OW=31
    logic        v_def = 1'b0;
    logic [37:0] d_def = '0;
    logic        ov_def;
    logic [61:0] od_def;
    cic_decimator dut_def (
        .lr_clock(clk), .i_reset_n(rst_n), .i_valid(v_def), .i_data(d_def),
        .o_valid(ov_def), .o_data(od_def));

    // Small configuration: IW=8 N=1 R=4 M=1 CH=1 -> GW=OW=10
    logic       v_n1 = 1'b0;
    logic [7:0] d_n1 = '0;
    logic       ov_n1;
    logic [9:0] od_n1;
    cic_decimator #(.IW(8), .N(1), .R(4), .M(1), .CH(1)) dut_n1 (
        .lr_clock(clk), .i_reset_n(rst_n), .i_valid(v_n1), .i_data(d_n1),
        .o_valid(ov_n1), .o_data(od_n1));

    // Truncated output: defaults with OW=16
    logic        v_ow = 1'b0;
    logic [37:0] d_ow = '0;
    logic        ov_ow;
    logic [31:0] od_ow;
    cic_decimator #(.OW(16)) dut_ow (
        .lr_clock(clk), .i_reset_n(rst_n), .i_valid(v_ow), .i_data(d_ow),
        .o_valid(ov_ow), .o_data(od_ow));

    typedef struct {
        int     cyc;
        longint d0;
        longint d1;
    } exp_t;

    exp_t   q_def[$];
    exp_t   q_n1[$];
    exp_t   q_ow[$];
    longint obs0[$];
    longint obs1[$];
    longint fresh_q[$];

    // Golden model state, indexed by instance id (0 def, 1 n1, 2 ow)
    longint ms_int  [3][2][6];
    longint ms_hist [3][2][6][2];
    int     ms_ph   [3];

    task automatic mdl_reset();
        for (int i = 0; i < 3; i++) begin
            ms_ph[i] = 0;
            for (int c = 0; c < 2; c++)
                for (int k = 0; k < 6; k++) begin
                    ms_int[i][c][k]     = 0;
                    ms_hist[i][c][k][0] = 0;
                    ms_hist[i][c][k][1] = 0;
                end
        end
    endtask

    // One accepted sample through a sample-rate model; rdy=1 when a decimated output results.
    task automatic mdl_sample(input int id, input int n, input int r, input int m,
                              input int gw, input int ow, input longint x0, input longint x1,
                              output bit rdy, output longint y0, output longint y1);
        longint mask;
        longint nw[6];
        longint v, t, xs;
        mask = (longint'(1) << gw) - 1;
        rdy  = (ms_ph[id] == r - 1);
        y0   = 0;
        y1   = 0;
        for (int c = 0; c < 2; c++) begin
            xs = ((c == 0) ? x0 : x1) & mask;
            nw[0] = (ms_int[id][c][0] + xs) & mask;
            for (int k = 1; k < n; k++)
                nw[k] = (ms_int[id][c][k] + ms_int[id][c][k-1]) & mask;
            for (int k = 0; k < n; k++)
                ms_int[id][c][k] = nw[k];
            if (rdy) begin
                v = nw[n-1];
                for (int k = 0; k < n; k++) begin
                    t = v;
                    v = (t - ms_hist[id][c][k][m-1]) & mask;
                    ms_hist[id][c][k][1] = ms_hist[id][c][k][0];
                    ms_hist[id][c][k][0] = t;
                end
                v = v >> (gw - ow);
                if (c == 0) y0 = v; else y1 = v;
            end
        end
        ms_ph[id] = rdy ? 0 : ms_ph[id] + 1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        v_def = 1'b0; v_n1 = 1'b0; v_ow = 1'b0;
        mdl_reset();
        q_def.delete(); q_n1.delete(); q_ow.delete();
        obs0.delete(); obs1.delete();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Drive the default DUT, score every strobe against the model, record observed outputs.
    task automatic run_def(input int nsamp, input longint x0, input longint x1, input int gap);
        int     sent = 0;
        bit     rdy;
        longint y0, y1;
        exp_t   e;
        obs0.delete(); obs1.delete();
        for (int step = 0; step < nsamp * gap + 10; step++) begin
            @(negedge clk);
            if (ov_def) begin
                n_cmp++;
                if (q_def.size() == 0) begin
                    n_fail++;
                    $display("FAIL def_unexpected_strobe: o_valid=1 at cycle %0d, required 0", cyc);
                end else begin
                    e = q_def.pop_front();
                    n_cmp++;
                    if (cyc !== e.cyc) begin
                        n_fail++;
                        $display("FAIL def_latency: strobe at cycle %0d, required %0d", cyc, e.cyc);
                    end
                    n_cmp++;
                    if ({33'b0, od_def[30:0]} !== e.d0) begin
                        n_fail++;
                        $display("FAIL def_ch0_data: got %0h, required %0h", od_def[30:0], e.d0);
                    end
                    n_cmp++;
                    if ({33'b0, od_def[61:31]} !== e.d1) begin
                        n_fail++;
                        $display("FAIL def_ch1_data: got %0h, required %0h", od_def[61:31], e.d1);
                    end
                end
                obs0.push_back(longint'($signed(od_def[30:0])));
                obs1.push_back(longint'($signed(od_def[61:31])));
            end else if (q_def.size() > 0 && q_def[0].cyc <= cyc) begin
                n_cmp++;
                n_fail++;
                $display("FAIL def_missing_strobe: o_valid=0 at cycle %0d, required 1", cyc);
                void'(q_def.pop_front());
            end
            if (sent < nsamp && (step % gap) == 0) begin
                v_def = 1'b1;
                d_def = {x1[18:0], x0[18:0]};
                mdl_sample(0, 3, 16, 1, 31, 31, x0, x1, rdy, y0, y1);
                if (rdy) begin
                    e.cyc = cyc + 4;
                    e.d0  = y0;
                    e.d1  = y1;
                    q_def.push_back(e);
                end
                sent++;
            end else begin
                v_def = 1'b0;
            end
        end
        n_cmp++;
        if (q_def.size() != 0) begin
            n_fail++;
            $display("FAIL def_leftover: %0d strobes outstanding, required 0", q_def.size());
        end
    endtask

    task automatic check_steady(input string name, input longint want0, input longint want1,
                                input int nblk);
        n_cmp++;
        if (obs0.size() != nblk) begin
            n_fail++;
            $display("FAIL %s_count: %0d outputs, required %0d", name, obs0.size(), nblk);
        end
        for (int i = 3; i < obs0.size(); i++) begin
            n_cmp++;
            if (obs0[i] !== want0 || obs1[i] !== want1) begin
                n_fail++;
                $display("FAIL %s_steady[%0d]: got %0d/%0d, required %0d/%0d",
                         name, i, obs0[i], obs1[i], want0, want1);
            end
        end
    endtask

    task automatic test_reset();
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({ov_def, ov_n1, ov_ow} !== 3'b000) begin
            n_fail++;
            $display("FAIL reset_valid: got %b, required 000", {ov_def, ov_n1, ov_ow});
        end
        n_cmp++;
        if (od_def !== '0 || od_n1 !== '0 || od_ow !== '0) begin
            n_fail++;
            $display("FAIL reset_data: got %0h/%0h/%0h, required 0", od_def, od_n1, od_ow);
        end
        do_reset();
    endtask

    task automatic test_pos_fullscale();
        do_reset();
        run_def(128, 262143, 262143, 1);
        fresh_q = obs0;
        check_steady("pos_fs", 1073737728, 1073737728, 8);
    endtask

    task automatic test_neg_fullscale();
        do_reset();
        run_def(128, -262144, -262144, 1);
        check_steady("neg_fs", -1073741824, -1073741824, 8);
    endtask

    task automatic test_channels();
        do_reset();
        run_def(128, 100, -7, 1);
        check_steady("chan", 409600, -28672, 8);
    endtask

    task automatic test_sparse();
        do_reset();
        run_def(128, 5, 5, 3);
        check_steady("sparse", 20480, 20480, 8);
    endtask

    task automatic test_reset_mid_block();
        do_reset();
        run_def(58, 262143, 262143, 1);
        #2 rst_n = 1'b0;
        #1;
        n_cmp++;
        if (ov_def !== 1'b0 || od_def !== '0) begin
            n_fail++;
            $display("FAIL midrst_clear: o_valid=%b o_data=%0h, required 0/0", ov_def, od_def);
        end
        mdl_reset();
        q_def.delete();
        @(negedge clk);
        rst_n = 1'b1;
        run_def(128, 262143, 262143, 1);
        n_cmp++;
        if (obs0.size() != fresh_q.size()) begin
            n_fail++;
            $display("FAIL midrst_count: %0d outputs, required %0d", obs0.size(), fresh_q.size());
        end
        for (int i = 0; i < obs0.size() && i < fresh_q.size(); i++) begin
            n_cmp++;
            if (obs0[i] !== fresh_q[i]) begin
                n_fail++;
                $display("FAIL midrst_seq[%0d]: got %0d, required %0d", i, obs0[i], fresh_q[i]);
            end
        end
    endtask

    task automatic test_dc_ramp_n1();
        int     sent = 0;
        int     first = -1;
        int     drive0 = -1;
        int     nstrobe = 0;
        bit     rdy;
        longint y0, y1;
        exp_t   e;
        do_reset();
        for (int step = 0; step < 30; step++) begin
            @(negedge clk);
            if (ov_n1) begin
                nstrobe++;
                if (first < 0) first = cyc;
                n_cmp++;
                if (od_n1 !== 10'd4) begin
                    n_fail++;
                    $display("FAIL n1_dc_value: got %0d, required 4", od_n1);
                end
                n_cmp++;
                if (q_n1.size() == 0) begin
                    n_fail++;
                    $display("FAIL n1_unexpected_strobe: o_valid=1 at cycle %0d", cyc);
                end else begin
                    e = q_n1.pop_front();
                    if (cyc !== e.cyc || {54'b0, od_n1} !== e.d0) begin
                        n_fail++;
                        $display("FAIL n1_model: cycle %0d data %0d, required cycle %0d data %0d",
                                 cyc, od_n1, e.cyc, e.d0);
                    end
                end
            end
            if (sent < 20) begin
                if (drive0 < 0) drive0 = cyc;
                v_n1 = 1'b1;
                d_n1 = 8'd1;
                mdl_sample(1, 1, 4, 1, 10, 10, 1, 0, rdy, y0, y1);
                if (rdy) begin
                    e.cyc = cyc + 2;
                    e.d0  = y0;
                    e.d1  = 0;
                    q_n1.push_back(e);
                end
                sent++;
            end else begin
                v_n1 = 1'b0;
            end
        end
        n_cmp++;
        if (first !== drive0 + 5) begin
            n_fail++;
            $display("FAIL n1_first_strobe: cycle %0d, required %0d", first, drive0 + 5);
        end
        n_cmp++;
        if (nstrobe !== 5 || q_n1.size() != 0) begin
            n_fail++;
            $display("FAIL n1_strobe_count: got %0d (left %0d), required 5", nstrobe, q_n1.size());
        end
    endtask

    task automatic test_ow_truncation();
        int     sent = 0;
        int     nstrobe = 0;
        bit     rdy;
        longint y0, y1;
        exp_t   e;
        do_reset();
        for (int step = 0; step < 138; step++) begin
            @(negedge clk);
            if (ov_ow) begin
                nstrobe++;
                n_cmp++;
                if (q_ow.size() == 0) begin
                    n_fail++;
                    $display("FAIL ow_unexpected_strobe: o_valid=1 at cycle %0d", cyc);
                end else begin
                    e = q_ow.pop_front();
                    if (cyc !== e.cyc || {48'b0, od_ow[15:0]} !== e.d0 ||
                        {48'b0, od_ow[31:16]} !== e.d1) begin
                        n_fail++;
                        $display("FAIL ow_model: cycle %0d data %0h, required cycle %0d data %0h/%0h",
                                 cyc, od_ow, e.cyc, e.d1, e.d0);
                    end
                end
                if (nstrobe >= 4) begin
                    n_cmp++;
                    if (od_ow !== {16'd125, 16'd125}) begin
                        n_fail++;
                        $display("FAIL ow_steady: got %0d/%0d, required 125/125",
                                 od_ow[15:0], od_ow[31:16]);
                    end
                end
            end
            if (sent < 128) begin
                v_ow = 1'b1;
                d_ow = {19'd1000, 19'd1000};
                mdl_sample(2, 3, 16, 1, 31, 16, 1000, 1000, rdy, y0, y1);
                if (rdy) begin
                    e.cyc = cyc + 4;
                    e.d0  = y0;
                    e.d1  = y1;
                    q_ow.push_back(e);
                end
                sent++;
            end else begin
                v_ow = 1'b0;
            end
        end
        n_cmp++;
        if (nstrobe !== 8 || q_ow.size() != 0) begin
            n_fail++;
            $display("FAIL ow_strobe_count: got %0d (left %0d), required 8", nstrobe, q_ow.size());
        end
    endtask

    initial begin
        mdl_reset();
        test_reset();
        test_dc_ramp_n1();
        test_pos_fullscale();
        test_neg_fullscale();
        test_channels();
        test_sparse();
        test_reset_mid_block();
        test_ow_truncation();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/cic_decimator.md
# cic_decimator

Parametrised N-stage, multi-channel CIC decimation filter for the microphone-array audio path. It sits between the PDM/PCM capture front end and the downstream FIR/beamforming stages. It accepts one sample per channel on each `i_valid` strobe and emits one full-precision or truncated sample per channel every R accepted inputs. It replaces the fixed three-integrator, single-comb arrangement with configurable stage count N, differential delay M, decimation ratio R and channel count CH.

## Interface
- `IW`, 19: input sample width per channel, two's complement.
- `N`, 3: number of integrator/comb stage pairs, 1..6.
- `R`, 16: decimation ratio, 2..64.
- `M`, 1: comb differential delay, 1 or 2.
- `CH`, 2: number of parallel channels (L/R = 2).
- `GW`, IW + N*clog2(R*M): internal accumulator width, derived; must not be overridden.
- `OW`, GW: output width, OW <= GW.

Ports:
- `lr_clock`  in  1  sole clock; all state changes on the rising edge.
- `i_reset_n`  in  1  asynchronous, active-low reset.
- `i_valid`  in  1  one input sample per channel present this cycle.
- `i_data`  in  CH*IW  channel c occupies bits [c*IW +: IW].
- `o_valid`  out  1  one-cycle strobe: `o_data` holds a new decimated sample set.
- `o_data`  out  CH*OW  channel c occupies bits [c*OW +: OW].

## Operation
- **Reset.** While `i_reset_n` is low, the following are cleared to 0: all integrator registers, comb delay lines, comb pipeline registers, the phase counter, the valid token pipeline, `o_valid` and `o_data`.
- **Integrators.** On each cycle with `i_valid` = 1, every channel updates all N integrators simultaneously in register form:
  - I1 <= I1 + sext(x)
  - Ik <= Ik + I(k-1)_old
  - All arithmetic is GW-bit modulo 2^GW; wrap-around is intentional and must not saturate.
  - With `i_valid` = 0, the integrators hold their values.
- **Phase counter.** Counts accepted samples 0..R-1 and wraps to 0.
  - When `i_valid` = 1 and phase = R-1, the decimation register D loads the new IN value, i.e. IN_old + I(N-1)_old (or I1_old + x when N = 1).
  - A valid token enters the comb pipeline on the same edge.
- **Combs.** There are N registered stages, and the token advances one stage per cycle.
  - Stage k computes y = in − in delayed by M tokens; the M-deep delay line shifts only when the token passes that stage.
  - Arithmetic is GW-bit modular.
- **Output.**
  - `o_data` = comb stage N result >> (GW−OW), i.e. truncation toward −inf.
  - `o_valid` = token leaving stage N.
  - `o_data` holds its value between strobes.
- **Channels** are independent and share only the phase counter and the token pipeline.
- **Gain** is (R*M)^N. With the defaults (IW=19, N=3, R=16, M=1): GW = 31, DC gain = 4096.

## Timing
- **Throughput.** `i_valid` may be high every cycle. Since R >= 2, at most one token occupies each comb stage, and there is no backpressure.
- **Latency.** If the R-th sample of a block is sampled in cycle c, `o_valid` is high in exactly cycle c+N+1, for one cycle only.
- **Gaps in `i_valid`** stall the integrators and phase counter only. Tokens already in the comb pipeline keep advancing on each clock.
- **Reset asserted mid-operation:**
  - In-flight tokens are discarded, and no `o_valid` appears for a partially accumulated block.
  - After release, the first `o_valid` follows the R-th post-reset `i_valid`.
- **Reset timing.** Assertion is asynchronous. Deassertion is assumed synchronised upstream. The first accepted `i_valid` is the first rising edge with `i_reset_n` high.
- **Settling.** The first N·M output samples after reset are transient. From output N·M+1 onward, a constant input x produces the steady-state value x·(R·M)^N >> (GW−OW).

## Test plan
- **DC ramp-up** (N=1, R=4, M=1, CH=1, IW=8): hold x = 1 with `i_valid` = 1 continuously.
  - Required: `o_valid` every 4th cycle, first strobe in cycle 3+2.
  - `o_data` = 4 on every strobe.
- **Defaults, positive full scale:** x = +262143 on both channels, continuous valid.
  - Required: from the 4th output onward, `o_data` = 1073737728 per channel.
  - Transient outputs match the golden model bit-exactly.
- **Defaults, negative full scale:** x = −262144.
  - Required: steady output −1073741824, with no saturation.
  - Intermediate integrator wrap-around occurs and still yields bit-exact output versus a Python model.
- **Channel independence:** ch0 = +100, ch1 = −7, with defaults.
  - Required: steady outputs 409600 and −28672.
  - The channels never cross-contaminate.
- **Sparse valid:** defaults, `i_valid` high one cycle in three, x = 5.
  - Required: `o_valid` exactly N+1 = 4 cycles after every 16th strobe.
  - Steady `o_data` = 20480.
- **Reset mid-block:** assert `i_reset_n` = 0 after the 10th sample of a block, then release.
  - Required: `o_valid`/`o_data` go to 0 immediately.
  - The next `o_valid` occurs only after 16 new samples.
  - The outputs repeat the fresh-start sequence exactly.
- **OW truncation:** OW = 16 with defaults, x = 1000.
  - Required: steady `o_data` = (1000·4096) >> 15 = 125.
